// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
//
// Receives one UART frame from the serial line. A frame is a start bit, WIDTH
// data bits (LSB first), an optional parity bit and one stop bit. Each bit
// lasts PRESCALE CLK cycles. The receiver takes three samples around mid-bit
// and uses the majority value for the bit.
//
// Parity convention (matches the transmit path):
//   even type: parity bit = XOR of the data bits
//   odd type : parity bit = XNOR of the data bits
//
// Optional feature:
//   UART_RX_SYNC_EN  - When defined, RX_IN passes through a 2-flop
//                      synchronizer (reset value 1) before the FSM. This adds
//                      2 CLK cycles to every latency.
//                    - When undefined, RX_IN drives the FSM directly. The
//                      caller must then supply a synchronous input.
//
// Ports:
//   CLK         oversampling clock
//   RST         asynchronous active-low reset
//   RX_IN       serial line, idle high
//   PRESCALE    CLK cycles per bit (8, 16 or 32; any other value acts as 8)
//   PAR_EN      1 = frame carries a parity bit
//   PAR_TYP     0 = even, 1 = odd
//   P_DATA      last word received without error
//   data_valid  one-cycle pulse when P_DATA is updated
//   par_err     one-cycle pulse on a parity mismatch
//   stp_err     one-cycle pulse when the stop bit is sampled as 0
//
// PRESCALE, PAR_EN and PAR_TYP are captured when the start edge is seen.
// Changes to them while a frame is in progress are ignored.
// -----------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [WIDTH-1:0]      P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PRESCALE_W-1:0] ONE_P   = PRESCALE_W'(1);
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Map any unsupported prescale value to 8.
    function automatic logic [PRESCALE_W-1:0] decode_prescale(input logic [PRESCALE_W-1:0] p);
        case (p)
            PRESCALE_W'(8):  return PRESCALE_W'(8);
            PRESCALE_W'(16): return PRESCALE_W'(16);
            PRESCALE_W'(32): return PRESCALE_W'(32);
            default:         return PRESCALE_W'(8);
        endcase
    endfunction

    // Expected parity bit: XOR for even type, XNOR for odd type.
    function automatic logic expected_parity(input logic [WIDTH-1:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction

    // Majority of three samples.
    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchronizer. Reset value is 1 so the idle line does not look
    // like a start bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RX_IN;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;
`else
    assign rx_s = RX_IN;
`endif

    state_t                  state_q,      state_d;
    logic [PRESCALE_W-1:0]   edge_cnt_q,   edge_cnt_d;
    logic [CNT_W-1:0]        bit_cnt_q,    bit_cnt_d;
    logic [2:0]              samp_q,       samp_d;
    logic [WIDTH-1:0]        shift_q,      shift_d;
    logic [PRESCALE_W-1:0]   prescale_q,   prescale_d;
    logic                    par_en_q,     par_en_d;
    logic                    par_typ_q,    par_typ_d;
    logic                    par_bad_q,    par_bad_d;
    logic [WIDTH-1:0]        p_data_q,     p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_err_q,    par_err_d;
    logic                    stp_err_q,    stp_err_d;

    logic [PRESCALE_W-1:0]   half_s;
    logic                    last_edge_s;
    logic                    bit_s;

    assign half_s      = prescale_q >> 1;
    assign last_edge_s = (edge_cnt_q == (prescale_q - ONE_P));
    assign bit_s       = majority3(samp_q);

    // Next-state and datapath logic for the frame FSM.
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q == S_IDLE) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            // Inside a frame: step the bit-time counter and take the three
            // samples around mid-bit.
            if (last_edge_s) begin
                edge_cnt_d = '0;
            end else begin
                edge_cnt_d = edge_cnt_q + ONE_P;
            end
            if (edge_cnt_q == (half_s - ONE_P)) begin
                samp_d[0] = rx_s;
            end else if (edge_cnt_q == half_s) begin
                samp_d[1] = rx_s;
            end else if (edge_cnt_q == (half_s + ONE_P)) begin
                samp_d[2] = rx_s;
            end else begin
                samp_d = samp_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d    = S_START;
                    prescale_d = decode_prescale(PRESCALE);
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_bad_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                // A high majority means the start was a glitch. Return to
                // IDLE without any pulse.
                if (last_edge_s) begin
                    state_d = bit_s ? S_IDLE : S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (last_edge_s) begin
                    shift_d = {bit_s, shift_q[WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (last_edge_s) begin
                    par_bad_d = (bit_s != expected_parity(shift_q, par_typ_q));
                    state_d   = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (last_edge_s) begin
                    state_d   = S_IDLE;
                    par_err_d = par_bad_q;
                    stp_err_d = ~bit_s;
                    // A failed frame leaves the previous word in P_DATA.
                    if (bit_s && !par_bad_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        p_data_d = p_data_q;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame FSM state and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= 3'b000;
            shift_q      <= '0;
            prescale_q   <= PRESCALE_W'(8);
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame
//
// Scoreboard bench for uart_rx_frame. Each stimulus task pushes the expected
// output event into a queue: the flags, the P_DATA value and the edge number
// of the pulse. A monitor pops one entry for every output pulse it sees and
// compares the two.
//
// Timing convention:
//   - t0 is the first posedge at which the line is low.
//   - A pulse registered at posedge k is seen at the following negedge,
//     when cyc == k.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] PRESCALE = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx_frame #(.WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
        int         at;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] exp_pdata = 8'h00;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every output pulse consumes one scoreboard entry.
    always @(negedge CLK) begin
        if (RST && (data_valid || par_err || stp_err)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got dv=%0b pe=%0b se=%0b at cycle %0d, expected none",
                         data_valid, par_err, stp_err, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("flags", int'({data_valid, par_err, stp_err}), int'({e.dv, e.pe, e.se}));
                chk("p_data", int'(P_DATA), int'(e.pd));
                chk("pulse_cycle", cyc, e.at);
            end
        end
    end

    // Send one 8-bit frame and push its expected result. Config inputs are
    // scrambled after the start bit to show they are only captured at the
    // start. 'extra' is the detection delay when the receiver is still in
    // STOP as the line drops.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic ptyp, input logic pbit, input logic sbit,
                              input logic exp_dv, input logic exp_pe, input logic exp_se,
                              input int extra);
        exp_t e;
        int   t0;
        int   n;
        n  = 10 + (pen ? 1 : 0);
        t0 = cyc + 1;
        if (exp_dv) exp_pdata = d;
        e.dv = exp_dv;
        e.pe = exp_pe;
        e.se = exp_se;
        e.pd = exp_pdata;
        e.at = t0 + extra + n * p + SYNC_LAT;
        sb_q.push_back(e);
        PRESCALE = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        RX_IN    = 1'b0;
        repeat (p) @(negedge CLK);
        PRESCALE = (p == 32) ? 6'd8 : 6'd32;
        PAR_EN   = ~pen;
        PAR_TYP  = ~ptyp;
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (p) @(negedge CLK);
        end
        if (pen) begin
            RX_IN = pbit;
            repeat (p) @(negedge CLK);
        end
        RX_IN = sbit;
        repeat (p) @(negedge CLK);
        RX_IN = 1'b1;
    endtask

    initial begin
        int         wait_cnt;
        logic [7:0] rd;

        // Reset state.
        repeat (3) @(negedge CLK);
        chk("reset_p_data", int'(P_DATA), 0);
        chk("reset_data_valid", int'(data_valid), 0);
        chk("reset_par_err", int'(par_err), 0);
        chk("reset_stp_err", int'(stp_err), 0);
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        // 0xA5, P=8, even parity, parity bit 0 (four ones) -> valid at t0+88.
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        repeat (10) @(negedge CLK);

        // 0x3C, P=16, odd parity needs 1; send 0 -> par_err at t0+176.
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        repeat (10) @(negedge CLK);

        // 0x81, P=8, no parity, stop bit 0 -> stp_err at t0+80.
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        repeat (10) @(negedge CLK);

        // Glitch: low for 2 cycles at P=16. The receiver is back in IDLE at
        // t0+16, so a frame whose line drops at t0+17 is detected at once.
        PRESCALE = 6'd16;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (15) @(negedge CLK);
        send_frame(8'h42, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        repeat (10) @(negedge CLK);

        // Back-to-back at P=32. The second start bit begins on the edge of the
        // first stop decision; IDLE sees it one edge later.
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'hAA, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        repeat (10) @(negedge CLK);

        // Reset during data bit 4 of a 0x33 frame: outputs clear, no pulse.
        rd       = 8'h33;
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RX_IN = rd[i];
            repeat (8) @(negedge CLK);
        end
        RX_IN = rd[4];
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("midreset_p_data", int'(P_DATA), 0);
        chk("midreset_data_valid", int'(data_valid), 0);
        chk("midreset_par_err", int'(par_err), 0);
        chk("midreset_stp_err", int'(stp_err), 0);
        RX_IN     = 1'b1;
        exp_pdata = 8'h00;
        @(negedge CLK);
        RST = 1'b1;
        repeat (10) @(negedge CLK);
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        // Drain the scoreboard within a bounded wait, then watch for stray
        // pulses.
        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 2000) begin
            @(negedge CLK);
            wait_cnt++;
        end
        chk("scoreboard_pending", sb_q.size(), 0);
        repeat (50) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
